cmd_uart_bridge: RTL and testbench

- Sits between the UART transceiver and the command dispatcher.
- Receive side: assembles three consecutive UART bytes, MSB byte first, into a 24-bit command. Presents it with a level cmd_rdy that the dispatcher clears with clr_cmd_rdy.
- Transmit side: accepts one-byte responses from the dispatcher and drives the UART transmitter with trmt/tx_data, reporting completion on resp_sent.
- An inter-byte timeout discards partial frames so the host can resynchronise.

---
 rtl/osc_cmd_pkg.sv | 30 +++
 rtl/cmd_resp_tx.sv | 61 ++++++
 rtl/cmd_uart_bridge.sv | 92 +++++++++
 tb/tb_cmd_uart_bridge.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/osc_cmd_pkg.sv
// Shared definitions for the host command path: widths, state encodings and
// the opcode set understood by the command dispatcher.
package osc_cmd_pkg;

  localparam int CMD_W  = 24;
  localparam int BYTE_W = 8;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_BUSY = 1'b1
  } tx_state_t;

  typedef enum logic [1:0] {
    IDX_HI  = 2'd0,
    IDX_MID = 2'd1,
    IDX_LO  = 2'd2
  } rx_idx_t;

  // Opcodes carried in cmd[23:16], decoded by the dispatcher.
  localparam logic [7:0] OP_DUMP_CH1  = 8'h01;
  localparam logic [7:0] OP_DUMP_CH2  = 8'h02;
  localparam logic [7:0] OP_DUMP_CH3  = 8'h03;
  localparam logic [7:0] OP_CFG_GAIN  = 8'h04;
  localparam logic [7:0] OP_TRIG_LVL  = 8'h05;
  localparam logic [7:0] OP_TRIG_POS  = 8'h06;
  localparam logic [7:0] OP_SET_DEC   = 8'h07;
  localparam logic [7:0] OP_TRIG_CFG  = 8'h08;
  localparam logic [7:0] OP_WRITE_EEP = 8'h09;

endpackage

// File: rtl/cmd_resp_tx.sv
// Response transmit sequencer: latches one response byte, pulses trmt to the
// UART transmitter and reports resp_sent once the transmitter signals tx_done.
module cmd_resp_tx
  import osc_cmd_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              send_resp,
  input  logic [BYTE_W-1:0] resp_data,
  input  logic              tx_done,
  output logic              trmt,
  output logic [BYTE_W-1:0] tx_data,
  output logic              resp_sent
);

  // Handshake: send_resp is honoured only in TX_IDLE and not in the cycle
  // resp_sent is high; the requester must wait for resp_sent before the next
  // request. tx_done is only meaningful in TX_BUSY.
  tx_state_t state, state_nxt;
  logic      load;
  logic      sent_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= TX_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    sent_nxt  = 1'b0;
    case (state)
      TX_IDLE: begin
        if (send_resp && !resp_sent) begin
          load      = 1'b1;
          state_nxt = TX_BUSY;
        end
      end
      TX_BUSY: begin
        if (tx_done) begin
          sent_nxt  = 1'b1;
          state_nxt = TX_IDLE;
        end
      end
      default: state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trmt      <= 1'b0;
      resp_sent <= 1'b0;
      tx_data   <= '0;
    end else begin
      trmt      <= load;
      resp_sent <= sent_nxt;
      if (load) tx_data <= resp_data;
    end
  end

endmodule

// File: rtl/cmd_uart_bridge.sv
// Bridge between the UART and the command dispatcher: packs three received
// bytes (MSB first) into a 24-bit command and forwards one-byte responses.
module cmd_uart_bridge
  import osc_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              clr_rx_rdy,
  output logic [CMD_W-1:0]  cmd,
  output logic              cmd_rdy,
  input  logic              clr_cmd_rdy,
  input  logic              send_resp,
  input  logic [BYTE_W-1:0] resp_data,
  output logic              trmt,
  output logic [BYTE_W-1:0] tx_data,
  input  logic              tx_done,
  output logic              resp_sent,
  output logic              frame_err
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  rx_idx_t         idx;
  logic [TO_W-1:0] to_cnt;
  logic            accept;
  logic            timeout;

  // A pending command blocks reception so cmd stays stable until consumed.
  assign accept     = rx_rdy & ~cmd_rdy;
  assign clr_rx_rdy = accept;
  assign timeout    = (idx != IDX_HI) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= IDX_HI;
      to_cnt    <= '0;
      cmd       <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (accept) begin
        to_cnt <= '0;
        case (idx)
          IDX_HI: begin
            cmd[23:16] <= rx_data;
            idx        <= IDX_MID;
          end
          IDX_MID: begin
            cmd[15:8] <= rx_data;
            idx       <= IDX_LO;
          end
          IDX_LO: begin
            cmd[7:0] <= rx_data;
            idx      <= IDX_HI;
          end
          default: idx <= IDX_HI;
        endcase
      end else if (idx == IDX_HI) begin
        to_cnt <= '0;
      end else if (timeout) begin
        // Drop the partial frame; already-written cmd bytes are left alone.
        idx       <= IDX_HI;
        to_cnt    <= '0;
        frame_err <= 1'b1;
      end else begin
        to_cnt <= to_cnt + TO_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          cmd_rdy <= 1'b0;
    else if (clr_cmd_rdy)                cmd_rdy <= 1'b0;
    else if (accept && (idx == IDX_LO))  cmd_rdy <= 1'b1;
  end

  cmd_resp_tx u_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .send_resp (send_resp),
    .resp_data (resp_data),
    .tx_done   (tx_done),
    .trmt      (trmt),
    .tx_data   (tx_data),
    .resp_sent (resp_sent)
  );

endmodule

// File: tb/tb_cmd_uart_bridge.sv
// Bench for cmd_uart_bridge: directed UART/dispatcher traffic against a
// cycle-level behavioural model, plus hand-computed literal expectations.
module tb_cmd_uart_bridge;

  localparam int T = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp_data;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        resp_sent;
  logic        frame_err;

  int n_checks = 0;
  int n_errors = 0;
  int n_ferr   = 0;

  always #5 clk = ~clk;

  cmd_uart_bridge #(.TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_rdy      (rx_rdy),
    .rx_data     (rx_data),
    .clr_rx_rdy  (clr_rx_rdy),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .send_resp   (send_resp),
    .resp_data   (resp_data),
    .trmt        (trmt),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .resp_sent   (resp_sent),
    .frame_err   (frame_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_nbytes = 0;   // bytes of the current frame received so far
  int          m_idle   = 0;   // idle cycles since the last byte of this frame
  logic [23:0] m_cmd    = '0;
  logic        m_rdy    = 1'b0;
  logic        m_ferr   = 1'b0;
  logic        m_busy   = 1'b0;
  logic        m_trmt   = 1'b0;
  logic        m_sent   = 1'b0;
  logic [7:0]  m_tx     = '0;

  always @(posedge clk or negedge rst_n) begin : model_b
    bit acc;
    bit set_rdy;
    bit new_sent;
    if (!rst_n) begin
      m_nbytes = 0; m_idle = 0; m_cmd = '0; m_rdy = 1'b0; m_ferr = 1'b0;
      m_busy = 1'b0; m_trmt = 1'b0; m_sent = 1'b0; m_tx = '0;
    end else begin
      acc     = rx_rdy && !m_rdy;
      set_rdy = 1'b0;
      m_ferr  = 1'b0;
      if (acc) begin
        case (m_nbytes)
          0:       m_cmd = {rx_data, m_cmd[15:0]};
          1:       m_cmd = {m_cmd[23:16], rx_data, m_cmd[7:0]};
          default: m_cmd = {m_cmd[23:8], rx_data};
        endcase
        m_idle   = 0;
        m_nbytes = m_nbytes + 1;
        if (m_nbytes == 3) begin
          m_nbytes = 0;
          set_rdy  = 1'b1;
        end
      end else if (m_nbytes > 0) begin
        m_idle = m_idle + 1;
        if (m_idle == T) begin
          m_nbytes = 0;
          m_idle   = 0;
          m_ferr   = 1'b1;
        end
      end
      if (clr_cmd_rdy)  m_rdy = 1'b0;
      else if (set_rdy) m_rdy = 1'b1;

      m_trmt   = 1'b0;
      new_sent = 1'b0;
      if (m_busy && tx_done) begin
        m_busy   = 1'b0;
        new_sent = 1'b1;
      end else if (!m_busy && send_resp && !m_sent) begin
        m_busy = 1'b1;
        m_trmt = 1'b1;
        m_tx   = resp_data;
      end
      m_sent = new_sent;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("clr_rx_rdy", 32'(clr_rx_rdy), 32'(rx_rdy && !m_rdy));
    check("cmd",        32'(cmd),        32'(m_cmd));
    check("cmd_rdy",    32'(cmd_rdy),    32'(m_rdy));
    check("frame_err",  32'(frame_err),  32'(m_ferr));
    check("trmt",       32'(trmt),       32'(m_trmt));
    check("tx_data",    32'(tx_data),    32'(m_tx));
    check("resp_sent",  32'(resp_sent),  32'(m_sent));
    if (frame_err === 1'b1) n_ferr++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_rdy  = 1'b1;
    rx_data = b;
    #1;
    check("clr_rx_rdy_same_cycle", 32'(clr_rx_rdy), 32'(1));
    @(posedge clk);
    #1;
    rx_rdy = 1'b0;
    tick(gap);
  endtask

  task automatic consume_cmd;
    clr_cmd_rdy = 1'b1;
    tick(1);
    clr_cmd_rdy = 1'b0;
    check("cmd_rdy_cleared", 32'(cmd_rdy), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete by %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n = 1'b0; rx_rdy = 1'b0; rx_data = '0; clr_cmd_rdy = 1'b0;
    send_resp = 1'b0; resp_data = '0; tx_done = 1'b0;
    tick(3);
    check("reset_cmd",     32'(cmd),     32'(0));
    check("reset_cmd_rdy", 32'(cmd_rdy), 32'(0));
    check("reset_tx_data", 32'(tx_data), 32'(0));
    check("reset_trmt",    32'(trmt),    32'(0));
    rst_n = 1'b1;
    tick(2);

    // Normal frame
    send_byte(8'h02, 2);
    send_byte(8'h1D, 3);
    send_byte(8'h00, 0);
    check("normal_cmd",     32'(cmd),     32'(24'h021D00));
    check("normal_cmd_rdy", 32'(cmd_rdy), 32'(1));
    check("model_normal",   32'(m_cmd),   32'(24'h021D00));
    tick(2);
    consume_cmd();
    tick(2);

    // Backpressure
    send_byte(8'h03, 1);
    send_byte(8'h00, 1);
    send_byte(8'h80, 0);
    check("bp_cmd", 32'(cmd), 32'(24'h030080));
    rx_rdy  = 1'b1;
    rx_data = 8'h04;
    #1;
    check("bp_blocked", 32'(clr_rx_rdy), 32'(0));
    tick(20);
    check("bp_cmd_stable", 32'(cmd), 32'(24'h030080));
    clr_cmd_rdy = 1'b1;
    tick(1);
    clr_cmd_rdy = 1'b0;
    check("bp_rdy_fell", 32'(cmd_rdy),    32'(0));
    check("bp_release",  32'(clr_rx_rdy), 32'(1));
    tick(1);
    rx_rdy = 1'b0;
    check("bp_byte_hi", 32'(cmd), 32'(24'h040080));
    send_byte(8'h11, 1);
    send_byte(8'h22, 0);
    check("bp_cmd2",   32'(cmd),   32'(24'h041122));
    check("model_bp",  32'(m_cmd), 32'(24'h041122));
    consume_cmd();
    tick(2);

    // Timeout
    send_byte(8'h05, 2);
    send_byte(8'h00, 0);
    tick(99);
    check("to_before", 32'(frame_err), 32'(0));
    tick(1);
    check("to_pulse",   32'(frame_err), 32'(1));
    check("to_no_rdy",  32'(cmd_rdy),   32'(0));
    tick(1);
    check("to_one_cycle", 32'(frame_err), 32'(0));
    check("to_pulse_count", 32'(n_ferr), 32'(1));
    send_byte(8'h05, 1);
    send_byte(8'h00, 1);
    send_byte(8'h07, 0);
    check("to_recover_cmd", 32'(cmd),     32'(24'h050007));
    check("to_recover_rdy", 32'(cmd_rdy), 32'(1));
    consume_cmd();
    tick(2);

    // Boundary: third byte on the 99th idle cycle
    send_byte(8'h0A, 2);
    send_byte(8'h0B, 0);
    tick(98);
    send_byte(8'h0C, 0);
    check("edge99_cmd", 32'(cmd),       32'(24'h0A0B0C));
    check("edge99_rdy", 32'(cmd_rdy),   32'(1));
    check("edge99_err", 32'(frame_err), 32'(0));
    consume_cmd();
    tick(2);
    // Byte arriving in the same cycle the timeout would fire
    send_byte(8'h0D, 1);
    send_byte(8'h0E, 0);
    tick(99);
    send_byte(8'h0F, 0);
    check("edge100_cmd", 32'(cmd),       32'(24'h0D0E0F));
    check("edge100_err", 32'(frame_err), 32'(0));
    check("edge100_cnt", 32'(n_ferr),    32'(1));
    consume_cmd();
    tick(2);

    // Response path
    send_resp = 1'b1; resp_data = 8'h2A;
    tick(1);
    send_resp = 1'b0;
    check("resp_trmt",    32'(trmt),    32'(1));
    check("resp_tx_data", 32'(tx_data), 32'(8'h2A));
    send_resp = 1'b1; resp_data = 8'h55;
    tick(1);
    send_resp = 1'b0;
    check("resp_busy_ignored", 32'(trmt),    32'(0));
    check("resp_busy_data",    32'(tx_data), 32'(8'h2A));
    tick(37);
    tx_done = 1'b1;
    tick(1);
    tx_done = 1'b0;
    check("resp_sent", 32'(resp_sent), 32'(1));
    send_resp = 1'b1; resp_data = 8'h66;
    tick(1);
    send_resp = 1'b0;
    check("resp_sent_one_cycle", 32'(resp_sent), 32'(0));
    check("resp_coincident_ign", 32'(trmt),      32'(0));
    tx_done = 1'b1;
    tick(1);
    tx_done = 1'b0;
    check("resp_idle_done_ign", 32'(resp_sent), 32'(0));
    send_resp = 1'b1; resp_data = 8'h77;
    tick(1);
    send_resp = 1'b0;
    check("resp2_trmt",    32'(trmt),    32'(1));
    check("resp2_tx_data", 32'(tx_data), 32'(8'h77));
    tick(3);
    tx_done = 1'b1;
    tick(1);
    tx_done = 1'b0;
    check("resp2_sent", 32'(resp_sent), 32'(1));
    tick(2);

    // Reset mid-frame and mid-transmit
    send_byte(8'h01, 1);
    send_byte(8'h02, 1);
    send_resp = 1'b1; resp_data = 8'h99;
    tick(1);
    send_resp = 1'b0;
    check("rst_pre_trmt", 32'(trmt), 32'(1));
    tick(2);
    rst_n = 1'b0;
    #1;
    check("rst_cmd",       32'(cmd),       32'(0));
    check("rst_cmd_rdy",   32'(cmd_rdy),   32'(0));
    check("rst_tx_data",   32'(tx_data),   32'(0));
    check("rst_trmt",      32'(trmt),      32'(0));
    check("rst_resp_sent", 32'(resp_sent), 32'(0));
    check("rst_frame_err", 32'(frame_err), 32'(0));
    tick(2);
    rst_n = 1'b1;
    tick(1);
    send_byte(8'h31, 1);
    send_byte(8'h32, 1);
    send_byte(8'h33, 0);
    check("post_rst_cmd", 32'(cmd),     32'(24'h313233));
    check("post_rst_rdy", 32'(cmd_rdy), 32'(1));
    tx_done = 1'b1;
    tick(1);
    tx_done = 1'b0;
    check("post_rst_no_sent", 32'(resp_sent), 32'(0));
    consume_cmd();
    tick(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
